exe_stage_mdu: RTL and testbench
================================

Name: exe_stage_mdu

Overview:
Parametrised execute stage for the pipelined MIPS core, with an iterative multiply/divide unit (MDU) and HI/LO registers. The single-cycle ALU path and its operand muxing (eshift, ealuimm) are kept and widened to WIDTH. MULT/MULTU/DIV/DIVU run over WIDTH cycles in the MDU. A stall output holds the ID/EXE pipeline registers while a result is pending.

Parameters:
WIDTH, 32, datapath width; power of 2, ≥ 8
SA_LSB, 6, LSB of the shift-amount field inside eimm
SAW, $clog2(WIDTH), shift-amount field width

Ports:
clk  in  1  rising-edge clock
clrn  in  1  asynchronous active-low reset
ealuc  in  4  ALU/MDU-read op select
ealuimm  in  1  ALU b source: 0 = eb, 1 = eimm
eshift  in  1  ALU a source: 0 = ea, 1 = zero-extended eimm[SA_LSB +: SAW]
ea  in  WIDTH  register operand a
eb  in  WIDTH  register operand b
eimm  in  WIDTH  extended immediate
emd_go  in  1  start MDU op (sampled only when not busy)
emd_op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
ealu  out  WIDTH  ALU result (combinational)
z  out  1  ealu == 0
emd_busy  out  1  MDU iterating
stall  out  1  pipeline hold request
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Reset (clrn = 0, asynchronous): hi = lo = 0, emd_busy = 0, FSM in IDLE, iteration counter = 0. Any in-flight op is aborted and its result discarded.
- ALU path: alua = eshift ? sa : ea; alub = ealuimm ? eimm : eb.
- ealuc encoding: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 LUI (alub << WIDTH/2), 6 SLL (alub << alua[SAW-1:0]), 7 SRL, 8 SRA, 9 SLT (signed, result 0/1), 10 SLTU, 11 MFHI (ealu = hi), 12 MFLO (ealu = lo), 13–15 NOR.
- ADD/SUB wrap modulo 2^WIDTH; no overflow trap.
- MDU FSM:
  - IDLE: on emd_go = 1, latch ea/eb/emd_op and take operand magnitudes for signed ops; set emd_busy; go to RUN with counter = WIDTH-1.
  - RUN: one radix-2 step per cycle (shift-add multiply, restoring divide); decrement counter.
  - Final step (counter = 0): apply sign fix-up, write hi/lo, clear emd_busy, return to IDLE.
- Timing: go sampled at edge 0; emd_busy = 1 for exactly WIDTH cycles; hi/lo updated at edge WIDTH.
- Results: MULT/MULTU → {hi,lo} = 2·WIDTH-bit product. DIV/DIVU → lo = quotient, hi = remainder. Signed remainder takes the sign of the dividend.
- Divide by zero: hi = ea, lo = all ones, same latency, no flag.
- Signed MIN / -1: lo = MIN, hi = 0.
- stall = emd_busy & (emd_go | ealuc == MFHI | ealuc == MFLO).
- emd_go while busy is ignored; stall holds it until IDLE, where it is accepted on the first cycle.
- MFHI/MFLO when not busy read hi/lo directly; no same-cycle bypass from a completing op. Stall drops in the cycle after write-back, so the read sees the new value.
- hi/lo change only on MDU completion or reset.

Optional Feature:
MDU_SIGNED_EN
- Defined: MULT and DIV are signed as above.
- Undefined: the sign fix-up logic is removed; MULT behaves as MULTU and DIV as DIVU. Area saving for unsigned-only builds.

Test Plan:
- ALU, ea=1, eb=2, eshift=0, ealuimm=0, ealuc=0,1,9 → ealu = 3 (z=0); 0xFFFFFFFF (z=0); 1. Then ea=eb=5, SUB → ealu = 0, z = 1.
- Shift, eshift=1, eimm[10:6]=4, eb=0x80000000, SRA → 0xF8000000; SRL → 0x08000000.
- MULT (MDU_SIGNED_EN defined), ea=0xFFFFFFFD, eb=7, emd_go pulse → emd_busy high exactly 32 cycles, then hi = 0xFFFFFFFF, lo = 0xFFFFFFEB.
- DIVU 100/7 → lo = 14, hi = 2. DIV (signed) 0xFFFFFFF9/2 → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF. DIVU 5/0 → hi = 5, lo = 0xFFFFFFFF.
- MFLO issued 1 cycle after a MULTU 3×4 go → stall = 1 until completion, then ealu = 12 and stall = 0. A second emd_go while busy → stall = 1 and the op starts only after the first completes.
- clrn pulsed low at cycle 10 of a DIV → emd_busy = 0 and hi = lo = 0 immediately (asynchronous). A following DIVU 9/3 runs clean: lo = 3, hi = 0.

Source files
------------

// File: rtl/exe_stage_mdu.sv
// Execute stage: combinational ALU plus iterative MDU (WIDTH cycles, HI/LO written at completion).
// stall holds ID/EXE while MDU busy and a new go or MFHI/MFLO waits; MDU_SIGNED_EN enables signed MULT/DIV.
module exe_stage_mdu #(
  parameter int WIDTH  = 32,
  parameter int SA_LSB = 6,
  parameter int SAW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [3:0]       ealuc,
  input  logic             ealuimm,
  input  logic             eshift,
  input  logic [WIDTH-1:0] ea,
  input  logic [WIDTH-1:0] eb,
  input  logic [WIDTH-1:0] eimm,
  input  logic             emd_go,
  input  logic [1:0]       emd_op,
  output logic [WIDTH-1:0] ealu,
  output logic             z,
  output logic             emd_busy,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [3:0] OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_AND  = 4'd2,  OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4,  OP_LUI  = 4'd5,  OP_SLL  = 4'd6,  OP_SRL  = 4'd7;
  localparam logic [3:0] OP_SRA  = 4'd8,  OP_SLT  = 4'd9,  OP_SLTU = 4'd10, OP_MFHI = 4'd11;
  localparam logic [3:0] OP_MFLO = 4'd12;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  typedef struct packed {
    logic is_div;
    logic neg_lo;
    logic neg_hi;
  } md_ctl_t;

  // ---------------- ALU ----------------
  logic [WIDTH-1:0] alua, alub;

  assign alua = eshift ? {{(WIDTH-SAW){1'b0}}, eimm[SA_LSB +: SAW]} : ea;
  assign alub = ealuimm ? eimm : eb;

  always_comb begin
    ealu = '0;
    case (ealuc)
      OP_ADD:  ealu = alua + alub;
      OP_SUB:  ealu = alua - alub;
      OP_AND:  ealu = alua & alub;
      OP_OR:   ealu = alua | alub;
      OP_XOR:  ealu = alua ^ alub;
      OP_LUI:  ealu = alub << (WIDTH/2);
      OP_SLL:  ealu = alub << alua[SAW-1:0];
      OP_SRL:  ealu = alub >> alua[SAW-1:0];
      OP_SRA:  ealu = $signed(alub) >>> alua[SAW-1:0];
      OP_SLT:  ealu = {{(WIDTH-1){1'b0}}, ($signed(alua) < $signed(alub))};
      OP_SLTU: ealu = {{(WIDTH-1){1'b0}}, (alua < alub)};
      OP_MFHI: ealu = hi;
      OP_MFLO: ealu = lo;
      default: ealu = ~(alua | alub);
    endcase
  end

  assign z = (ealu == '0);

  // ---------------- MDU ----------------
  state_t           state, state_nxt;
  logic [SAW-1:0]   cnt;
  logic [2*WIDTH:0] acc, acc_nxt;
  logic [WIDTH-1:0] mda, orig_a;
  md_ctl_t          ctl, ctl_ld;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] res_hi, res_lo;
  logic             start, last;

`ifdef MDU_SIGNED_EN
  logic op_signed, a_neg, b_neg;
  assign op_signed = ~emd_op[0];
  assign a_neg     = op_signed & ea[WIDTH-1];
  assign b_neg     = op_signed & eb[WIDTH-1];
  assign a_mag     = a_neg ? -ea : ea;
  assign b_mag     = b_neg ? -eb : eb;
  // Product sign and quotient sign both follow a^b; remainder follows the dividend.
  assign ctl_ld    = '{is_div: emd_op[1], neg_lo: a_neg ^ b_neg,
                       neg_hi: emd_op[1] ? a_neg : (a_neg ^ b_neg)};
`else
  logic unused_sign_sel;
  assign unused_sign_sel = emd_op[0];
  assign a_mag  = ea;
  assign b_mag  = eb;
  assign ctl_ld = '{is_div: emd_op[1], neg_lo: 1'b0, neg_hi: 1'b0};
`endif

  assign last = (cnt == '0);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (emd_go) state_nxt = S_RUN;
      S_RUN:   if (last)   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    emd_busy = (state == S_RUN);
    start    = (state == S_IDLE) & emd_go;
  end

  assign stall = emd_busy & (emd_go | (ealuc == OP_MFHI) | (ealuc == OP_MFLO));

  // One radix-2 step: low half holds multiplier / dividend bits, upper half the partial result.
  logic [WIDTH:0] mul_sum, div_sh, div_diff;

  always_comb begin
    mul_sum  = acc[2*WIDTH:WIDTH] + (acc[0] ? {1'b0, mda} : {(WIDTH+1){1'b0}});
    div_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff = div_sh - {1'b0, mda};
    if (ctl.is_div) begin
      if (div_diff[WIDTH]) acc_nxt = {1'b0, div_sh[WIDTH-1:0],   acc[WIDTH-2:0], 1'b0};
      else                 acc_nxt = {1'b0, div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      acc_nxt = {1'b0, mul_sum, acc[WIDTH-1:1]};
    end
  end

  logic [2*WIDTH-1:0] raw;
  assign raw = acc_nxt[2*WIDTH-1:0];

  always_comb begin
    res_hi = raw[2*WIDTH-1:WIDTH];
    res_lo = raw[WIDTH-1:0];
`ifdef MDU_SIGNED_EN
    if (ctl.is_div) begin
      if (ctl.neg_lo) res_lo = -raw[WIDTH-1:0];
      if (ctl.neg_hi) res_hi = -raw[2*WIDTH-1:WIDTH];
    end else if (ctl.neg_lo) begin
      {res_hi, res_lo} = -raw;
    end
`else
    if (ctl.neg_lo | ctl.neg_hi) begin
      res_hi = raw[2*WIDTH-1:WIDTH];
    end
`endif
    if (ctl.is_div && mda == '0) begin
      res_hi = orig_a;
      res_lo = '1;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      acc    <= '0;
      mda    <= '0;
      orig_a <= '0;
      ctl    <= '0;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
    end else if (start) begin
      acc    <= {{(WIDTH+1){1'b0}}, a_mag};
      mda    <= b_mag;
      orig_a <= ea;
      ctl    <= ctl_ld;
      cnt    <= SAW'(WIDTH-1);
    end else if (emd_busy) begin
      acc <= acc_nxt;
      cnt <= last ? '0 : cnt - 1'b1;
      if (last) begin
        hi <= res_hi;
        lo <= res_lo;
      end
    end
  end

endmodule

// File: tb/tb_exe_stage_mdu.sv
// Directed bench for exe_stage_mdu: ALU table, MDU results/latency, stall, async reset.
module tb_exe_stage_mdu;

  logic        clk = 1'b0;
  logic        clrn;
  logic [3:0]  ealuc;
  logic        ealuimm, eshift;
  logic [31:0] ea, eb, eimm;
  logic        emd_go;
  logic [1:0]  emd_op;
  logic [31:0] ealu, hi, lo;
  logic        z, emd_busy, stall;

  int n_cmp = 0;
  int n_err = 0;

`ifdef MDU_SIGNED_EN
  localparam logic [31:0] MULT_HI = 32'hFFFFFFFF, MULT_LO = 32'hFFFFFFEB;
  localparam logic [31:0] MM1_HI  = 32'h00000000, MM1_LO  = 32'h00000001;
  localparam logic [31:0] DIV_HI  = 32'hFFFFFFFF, DIV_LO  = 32'hFFFFFFFD;
  localparam logic [31:0] MIN_HI  = 32'h00000000, MIN_LO  = 32'h80000000;
`else
  localparam logic [31:0] MULT_HI = 32'h00000006, MULT_LO = 32'hFFFFFFEB;
  localparam logic [31:0] MM1_HI  = 32'hFFFFFFFE, MM1_LO  = 32'h00000001;
  localparam logic [31:0] DIV_HI  = 32'h00000001, DIV_LO  = 32'h7FFFFFFC;
  localparam logic [31:0] MIN_HI  = 32'h80000000, MIN_LO  = 32'h00000000;
`endif

  exe_stage_mdu #(.WIDTH(32), .SA_LSB(6), .SAW(5)) dut (
    .clk(clk), .clrn(clrn), .ealuc(ealuc), .ealuimm(ealuimm), .eshift(eshift),
    .ea(ea), .eb(eb), .eimm(eimm), .emd_go(emd_go), .emd_op(emd_op),
    .ealu(ealu), .z(z), .emd_busy(emd_busy), .stall(stall), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  op;
    logic        sh;
    logic        im;
    logic [31:0] a, b, imm, exp;
    logic        ez;
  } alu_vec_t;

  // Issue one MDU op and count the cycles emd_busy stays high (bounded).
  task automatic md_run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int cyc);
    @(negedge clk);
    ea = a; eb = b; emd_op = op; emd_go = 1'b1;
    ealuc = 4'd0; ealuimm = 1'b0; eshift = 1'b0;
    @(negedge clk);
    emd_go = 1'b0;
    cyc = 0;
    while (emd_busy === 1'b1 && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    clrn = 1'b0; emd_go = 1'b1; emd_op = 2'd0; ealuc = 4'd11;
    ealuimm = 1'b0; eshift = 1'b0; ea = 32'h5; eb = 32'h7; eimm = 32'h0;
    #3;
    n_cmp++; if (emd_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b exp 0", emd_busy); end
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b exp 0", stall); end
    n_cmp++; if ({hi, lo} !== 64'h0) begin n_err++; $display("FAIL reset_hilo: got %h exp 0", {hi, lo}); end
    n_cmp++; if (ealu !== 32'h0) begin n_err++; $display("FAIL reset_mfhi: got %h exp 0", ealu); end
    emd_go = 1'b0;
    @(negedge clk);
    clrn = 1'b1;
  endtask

  task automatic test_alu();
    alu_vec_t tbl [0:16];
    tbl[0]  = '{4'd0,  1'b0, 1'b0, 32'h1,        32'h2,        32'h0,        32'h3,        1'b0};
    tbl[1]  = '{4'd1,  1'b0, 1'b0, 32'h1,        32'h2,        32'h0,        32'hFFFFFFFF, 1'b0};
    tbl[2]  = '{4'd9,  1'b0, 1'b0, 32'h1,        32'h2,        32'h0,        32'h1,        1'b0};
    tbl[3]  = '{4'd1,  1'b0, 1'b0, 32'h5,        32'h5,        32'h0,        32'h0,        1'b1};
    tbl[4]  = '{4'd8,  1'b1, 1'b0, 32'h0,        32'h80000000, 32'h100,      32'hF8000000, 1'b0};
    tbl[5]  = '{4'd7,  1'b1, 1'b0, 32'h0,        32'h80000000, 32'h100,      32'h08000000, 1'b0};
    tbl[6]  = '{4'd6,  1'b1, 1'b0, 32'h0,        32'h1,        32'h100,      32'h10,       1'b0};
    tbl[7]  = '{4'd2,  1'b0, 1'b0, 32'hF0,       32'hFF0,      32'h0,        32'hF0,       1'b0};
    tbl[8]  = '{4'd3,  1'b0, 1'b0, 32'hF0,       32'hFF0,      32'h0,        32'hFF0,      1'b0};
    tbl[9]  = '{4'd4,  1'b0, 1'b0, 32'hF0,       32'hFF0,      32'h0,        32'hF00,      1'b0};
    tbl[10] = '{4'd13, 1'b0, 1'b0, 32'hF0,       32'hFF0,      32'h0,        32'hFFFFF00F, 1'b0};
    tbl[11] = '{4'd15, 1'b0, 1'b0, 32'hF0,       32'hFF0,      32'h0,        32'hFFFFF00F, 1'b0};
    tbl[12] = '{4'd5,  1'b0, 1'b1, 32'h0,        32'h0,        32'h1234,     32'h12340000, 1'b0};
    tbl[13] = '{4'd10, 1'b0, 1'b0, 32'h1,        32'hFFFFFFFF, 32'h0,        32'h1,        1'b0};
    tbl[14] = '{4'd9,  1'b0, 1'b0, 32'h1,        32'hFFFFFFFF, 32'h0,        32'h0,        1'b1};
    tbl[15] = '{4'd0,  1'b0, 1'b1, 32'hA,        32'h0,        32'hFFFFFFFF, 32'h9,        1'b0};
    tbl[16] = '{4'd0,  1'b0, 1'b0, 32'hFFFFFFFF, 32'h1,        32'h0,        32'h0,        1'b1};
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      ealuc = tbl[i].op; eshift = tbl[i].sh; ealuimm = tbl[i].im;
      ea = tbl[i].a; eb = tbl[i].b; eimm = tbl[i].imm;
      #1;
      n_cmp++;
      if ({ealu, z} !== {tbl[i].exp, tbl[i].ez}) begin
        n_err++;
        $display("FAIL alu_vec%0d: got ealu=%h z=%b exp ealu=%h z=%b", i, ealu, z, tbl[i].exp, tbl[i].ez);
      end
    end
  endtask

  task automatic test_mult();
    int cyc;
    md_run(2'b00, 32'hFFFFFFFD, 32'h7, cyc);
    n_cmp++; if (cyc != 32) begin n_err++; $display("FAIL mult_busy_cycles: got %0d exp 32", cyc); end
    n_cmp++; if ({hi, lo} !== {MULT_HI, MULT_LO}) begin n_err++; $display("FAIL mult_neg: got %h exp %h", {hi, lo}, {MULT_HI, MULT_LO}); end
    ealuc = 4'd12; #1;
    n_cmp++; if (ealu !== MULT_LO) begin n_err++; $display("FAIL mult_mflo: got %h exp %h", ealu, MULT_LO); end
    md_run(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, cyc);
    n_cmp++; if ({hi, lo} !== 64'hFFFFFFFE_00000001) begin n_err++; $display("FAIL multu_max: got %h exp fffffffe00000001", {hi, lo}); end
    md_run(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, cyc);
    n_cmp++; if ({hi, lo} !== {MM1_HI, MM1_LO}) begin n_err++; $display("FAIL mult_m1m1: got %h exp %h", {hi, lo}, {MM1_HI, MM1_LO}); end
  endtask

  task automatic test_div();
    int cyc;
    md_run(2'b11, 32'd100, 32'd7, cyc);
    n_cmp++; if (cyc != 32) begin n_err++; $display("FAIL divu_busy_cycles: got %0d exp 32", cyc); end
    n_cmp++; if ({hi, lo} !== {32'd2, 32'd14}) begin n_err++; $display("FAIL divu_100_7: got %h exp %h", {hi, lo}, {32'd2, 32'd14}); end
    ealuc = 4'd11; #1;
    n_cmp++; if (ealu !== 32'd2) begin n_err++; $display("FAIL divu_mfhi: got %h exp 2", ealu); end
    md_run(2'b10, 32'hFFFFFFF9, 32'd2, cyc);
    n_cmp++; if ({hi, lo} !== {DIV_HI, DIV_LO}) begin n_err++; $display("FAIL div_neg: got %h exp %h", {hi, lo}, {DIV_HI, DIV_LO}); end
    md_run(2'b11, 32'd5, 32'd0, cyc);
    n_cmp++; if (cyc != 32) begin n_err++; $display("FAIL div0_busy_cycles: got %0d exp 32", cyc); end
    n_cmp++; if ({hi, lo} !== {32'd5, 32'hFFFFFFFF}) begin n_err++; $display("FAIL divu_by_zero: got %h exp %h", {hi, lo}, {32'd5, 32'hFFFFFFFF}); end
    md_run(2'b10, 32'h80000000, 32'hFFFFFFFF, cyc);
    n_cmp++; if ({hi, lo} !== {MIN_HI, MIN_LO}) begin n_err++; $display("FAIL div_min_m1: got %h exp %h", {hi, lo}, {MIN_HI, MIN_LO}); end
  endtask

  task automatic test_mflo_stall();
    int ns;
    @(negedge clk);
    ea = 32'd3; eb = 32'd4; emd_op = 2'b01; emd_go = 1'b1; ealuc = 4'd0;
    @(negedge clk);
    emd_go = 1'b0; ealuc = 4'd12;
    ns = 0;
    #1;
    while (emd_busy === 1'b1 && ns < 100) begin
      if (stall === 1'b1) ns++;
      @(negedge clk);
      #1;
    end
    n_cmp++; if (ns != 32) begin n_err++; $display("FAIL mflo_stall_cycles: got %0d exp 32", ns); end
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL mflo_stall_release: got %b exp 0", stall); end
    n_cmp++; if (ealu !== 32'd12) begin n_err++; $display("FAIL mflo_value: got %h exp c", ealu); end
  endtask

  task automatic test_back_to_back();
    int ns, cyc;
    @(negedge clk);
    ea = 32'd6; eb = 32'd7; emd_op = 2'b01; emd_go = 1'b1; ealuc = 4'd0;
    @(negedge clk);
    ea = 32'd100; eb = 32'd7; emd_op = 2'b11;
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL b2b_stall: got %b exp 1", stall); end
    ns = 0;
    while (stall === 1'b1 && ns < 100) begin
      ns++;
      @(negedge clk);
      #1;
    end
    n_cmp++; if (ns != 32) begin n_err++; $display("FAIL b2b_stall_cycles: got %0d exp 32", ns); end
    n_cmp++; if ({hi, lo} !== {32'd0, 32'd42}) begin n_err++; $display("FAIL b2b_first: got %h exp %h", {hi, lo}, {32'd0, 32'd42}); end
    @(negedge clk);
    emd_go = 1'b0;
    #1;
    cyc = 0;
    while (emd_busy === 1'b1 && cyc < 100) begin
      cyc++;
      @(negedge clk);
      #1;
    end
    n_cmp++; if (cyc != 32) begin n_err++; $display("FAIL b2b_second_cycles: got %0d exp 32", cyc); end
    n_cmp++; if ({hi, lo} !== {32'd2, 32'd14}) begin n_err++; $display("FAIL b2b_second: got %h exp %h", {hi, lo}, {32'd2, 32'd14}); end
  endtask

  task automatic test_async_reset();
    int cyc;
    @(negedge clk);
    ea = 32'hFFFFFFF9; eb = 32'd2; emd_op = 2'b10; emd_go = 1'b1; ealuc = 4'd0;
    @(negedge clk);
    emd_go = 1'b0;
    repeat (9) @(negedge clk);
    #2 clrn = 1'b0;
    #1;
    n_cmp++; if (emd_busy !== 1'b0) begin n_err++; $display("FAIL arst_busy: got %b exp 0", emd_busy); end
    n_cmp++; if ({hi, lo} !== 64'h0) begin n_err++; $display("FAIL arst_hilo: got %h exp 0", {hi, lo}); end
    @(negedge clk);
    clrn = 1'b1;
    md_run(2'b11, 32'd9, 32'd3, cyc);
    n_cmp++; if (cyc != 32) begin n_err++; $display("FAIL post_rst_cycles: got %0d exp 32", cyc); end
    n_cmp++; if ({hi, lo} !== {32'd0, 32'd3}) begin n_err++; $display("FAIL post_rst_divu: got %h exp %h", {hi, lo}, {32'd0, 32'd3}); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_mult();
    test_div();
    test_mflo_stall();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
    $fatal(1);
  end

endmodule
